// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int MAX_LOCK_W = 3;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;

  function automatic logic [MAX_LOCK_W-1:0] sat_inc(input logic [MAX_LOCK_W-1:0] v,
                                                    input logic [MAX_LOCK_W-1:0] lim);
    return (v >= lim) ? lim : v + MAX_LOCK_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not win last time wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded locking that shares one 256x8 dmem between
// the CPU load/store path (port 0) and a secondary master (port 1).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [MAX_LOCK_W-1:0] LOCK_MAX = MAX_LOCK_W'(MAX_LOCK);

  arb_state_t            state_reg, state_next;
  logic [MAX_LOCK_W-1:0] cnt_reg, cnt_next;
  logic                  rr_reg, rr_next;
  logic [1:0]            pick_gnt, gnt_c, gnt, we_v;

  assign we_v = {we1, we0};

  rr_pick2 u_pick (
    .req  ({req1, req0}),
    .last (rr_reg),
    .gnt  (pick_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rr_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rr_reg    <= rr_next;
    end
  end

  always_comb begin
    gnt_c      = 2'b00;
    state_next = IDLE;
    cnt_next   = '0;
    rr_next    = rr_reg;
    // An owner that drops req loses the lock at once and the cycle is a plain tie-break.
    case (state_reg)
      LOCK0:   gnt_c = !req0 ? pick_gnt : ((cnt_reg == LOCK_MAX && req1) ? 2'b10 : 2'b01);
      LOCK1:   gnt_c = !req1 ? pick_gnt : ((cnt_reg == LOCK_MAX && req0) ? 2'b01 : 2'b10);
      default: gnt_c = pick_gnt;
    endcase
    gnt = gnt_c & {2{~reset}};
    if (gnt[0]) begin
      rr_next = 1'b0;
      if (lock0) begin
        state_next = LOCK0;
        cnt_next   = (state_reg == LOCK0) ? sat_inc(cnt_reg, LOCK_MAX) : MAX_LOCK_W'(1);
      end
    end else if (gnt[1]) begin
      rr_next = 1'b1;
      if (lock1) begin
        state_next = LOCK1;
        cnt_next   = (state_reg == LOCK1) ? sat_inc(cnt_reg, LOCK_MAX) : MAX_LOCK_W'(1);
      end
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Pure muxes keyed on the grant so an idle port's X never reaches the memory.
  assign mem_we   = gnt[0] ? we0    : (gnt[1] ? we1    : 1'b0);
  assign mem_addr = gnt[0] ? addr0  : (gnt[1] ? addr1  : '0);
  assign mem_di   = gnt[0] ? wdata0 : (gnt[1] ? wdata1 : '0);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= gnt[gi] & ~we_v[gi];
        if (gnt[gi] & ~we_v[gi]) rdata_reg <= mem_dout;
      end
    end
  end

  assign rvalid0 = g_ret[0].rvalid_reg;
  assign rvalid1 = g_ret[1].rvalid_reg;
  assign rdata0  = g_ret[0].rdata_reg;
  assign rdata1  = g_ret[1].rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter against an ownership/queue-level model.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic reset, mem_clr;
  logic req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di, mem_dout;

  logic [DW-1:0] mem [256];

  always #5 clk = ~clk;

  // The dmem instance the arbiter drives: combinational read, write on the edge.
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_di;
    end
  end

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_dout(mem_dout)
  );

  // Reference model: who owns the memory, how many locked grants in a row, who won last.
  int            m_owner, m_held, m_last;
  logic [DW-1:0] ref_mem [256];
  logic          exp_rv [2];
  logic [DW-1:0] exp_rd [2];
  int            n_err, n_chk, cyc, n_g0, n_g1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_last = 1;
    exp_rv = '{1'b0, 1'b0};
    exp_rd = '{8'h00, 8'h00};
  endtask

  task automatic step(input logic r0, w0, l0, input logic [7:0] a0, d0,
                      input logic r1, w1, l1, input logic [7:0] a1, d1);
    int g, gi;
    logic rq [2], wq [2], lk [2];
    logic [7:0] aq [2], dq [2];
    @(negedge clk);
    req0 = r0; we0 = r0 ? w0 : 1'bx; lock0 = r0 ? l0 : 1'bx;
    addr0 = r0 ? a0 : 8'hxx; wdata0 = r0 ? d0 : 8'hxx;
    req1 = r1; we1 = r1 ? w1 : 1'bx; lock1 = r1 ? l1 : 1'bx;
    addr1 = r1 ? a1 : 8'hxx; wdata1 = r1 ? d1 : 8'hxx;
    rq = '{r0, r1}; wq = '{w0, w1}; lk = '{l0, l1}; aq = '{a0, a1}; dq = '{d0, d1};
    if (m_owner >= 0 && rq[m_owner])
      g = (m_held >= ML && rq[1-m_owner]) ? 1 - m_owner : m_owner;
    else if (rq[0] && rq[1]) g = 1 - m_last;
    else if (rq[0]) g = 0;
    else if (rq[1]) g = 1;
    else g = -1;
    gi = (g < 0) ? 0 : g;
    #1;
    check("gnt0", gnt0, g == 0);
    check("gnt1", gnt1, g == 1);
    check("mem_we", mem_we, (g >= 0) ? wq[gi] : 1'b0);
    check("mem_addr", mem_addr, (g >= 0) ? aq[gi] : 8'h00);
    check("mem_di", mem_di, (g >= 0) ? dq[gi] : 8'h00);
    check("rvalid0", rvalid0, exp_rv[0]);
    check("rvalid1", rvalid1, exp_rv[1]);
    check("rdata0", rdata0, exp_rd[0]);
    check("rdata1", rdata1, exp_rd[1]);
    $display("cyc %0d req=%b%b gnt=%b%b we=%b addr=%02h di=%02h rv=%b%b rd0=%02h rd1=%02h",
             cyc, req1, req0, gnt1, gnt0, mem_we, mem_addr, mem_di, rvalid1, rvalid0, rdata0, rdata1);
    n_g0 += int'(gnt0 === 1'b1);
    n_g1 += int'(gnt1 === 1'b1);
    cyc++;
    exp_rv = '{1'b0, 1'b0};
    if (g >= 0) begin
      m_last = g;
      if (!wq[g]) begin
        exp_rv[g] = 1'b1;
        exp_rd[g] = ref_mem[aq[g]];
      end else begin
        ref_mem[aq[g]] = dq[g];
      end
      if (lk[g]) begin
        m_held  = (m_owner == g) ? ((m_held < ML) ? m_held + 1 : ML) : 1;
        m_owner = g;
      end else begin
        m_owner = -1; m_held = 0;
      end
    end else begin
      m_owner = -1; m_held = 0;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    n_err = 0; n_chk = 0; cyc = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    model_reset();
    reset = 1'b1; mem_clr = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // A write request during reset must not be granted or reach the memory.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h33; wdata0 = 8'h77;
    #1;
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rvalid0", rvalid0, 1'b0);
    check("rst_rvalid1", rvalid1, 1'b0);
    check("rst_rdata0", rdata0, 8'h00);
    check("rst_rdata1", rdata1, 8'h00);
    @(negedge clk);
    reset = 1'b0; mem_clr = 1'b0; req0 = 1'b0; we0 = 1'b0;

    // Single requester write then read-back.
    step(1, 1, 0, 8'h10, 8'h5A, 0, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    idle();
    check("rd_33_untouched", mem[8'h33], 8'h00);

    // Ties between unlocked readers alternate.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
    for (int i = 0; i < 5; i++) idle();
    step(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
    idle();

    // Port 1 holds a lock for three accesses, then port 0 gets in.
    n_g0 = 0; n_g1 = 0;
    step(0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h50, 8'h11);
    step(0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h51, 8'h22);
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h50, 8'h00);
    step(1, 0, 0, 8'h51, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    check("lock_n_gnt1", n_g1, 3);
    check("lock_n_gnt0", n_g0, 1);
    idle();

    // Continuous lock by port 1 against a waiting port 0 is cut after MAX_LOCK grants.
    n_g0 = 0; n_g1 = 0;
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h50, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h51, 8'h00, 1, 0, 1, 8'h50, 8'h00);
    check("starve_n_gnt0_before", n_g0, 0);
    step(1, 0, 0, 8'h51, 8'h00, 1, 0, 1, 8'h50, 8'h00);
    check("starve_n_gnt1", n_g1, 4);
    check("starve_n_gnt0", n_g0, 1);
    idle();

    // Reset hits while port 0 owns the lock and issues a write to 0x20.
    step(1, 0, 1, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; lock0 = 1'b1; addr0 = 8'h20; wdata0 = 8'hAA; req1 = 1'b0;
    #1;
    check("midlock_gnt0_pre", gnt0, 1'b1);
    check("midlock_rvalid0_pre", rvalid0, 1'b1);
    reset = 1'b1;
    #1;
    check("midlock_gnt0", gnt0, 1'b0);
    check("midlock_mem_we", mem_we, 1'b0);
    check("midlock_rvalid0", rvalid0, 1'b0);
    check("midlock_rvalid1", rvalid1, 1'b0);
    @(negedge clk);
    reset = 1'b0; req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0;
    model_reset();
    step(1, 0, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    idle();
    check("midlock_mem20", mem[8'h20], 8'h00);

    // Random traffic over a small address window to force read-after-write hits.
    for (int i = 0; i < 250; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           8'(8'h40 + $urandom_range(0, 7)), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           8'(8'h40 + $urandom_range(0, 7)), 8'($urandom));
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
